// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with a one-cycle fast path for divide-by-zero and signed overflow.
//
// state | meaning
// IDLE  | waiting for an accepted M-type op
// CALC  | one multiply/divide iteration per cycle
// DONE  | MD_Out_E valid, Done_MD pulses, pipeline released
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start_E,
  input  logic             Flush_E,
  input  logic [2:0]       MD_Op_E,
  input  logic [WIDTH-1:0] SrcA_E,
  input  logic [WIDTH-1:0] SrcB_E,
  output logic             Stall_MD,
  output logic             Done_MD,
  output logic             Busy_MD,
  output logic [WIDTH-1:0] MD_Out_E
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]        cnt;
  logic [2:0]           op;
  logic [WIDTH-1:0]     opnd;
  logic [2*WIDTH-1:0]   acc, acc_nxt, prod;
  logic                 neg_res, neg_rem;

  logic                 in_div, sgn_a, sgn_b, a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag, fast_res, final_res, quo, rem;
  logic                 div_zero, div_ovf, fast, accept, last, div_ge;
  logic [WIDTH:0]       mul_sum, div_shift, div_diff;

  // Operand decode for the incoming op
  always_comb begin
    in_div   = MD_Op_E[2];
    sgn_a    = (MD_Op_E == 3'd1) | (MD_Op_E == 3'd2) | (MD_Op_E == 3'd4) | (MD_Op_E == 3'd6);
    sgn_b    = (MD_Op_E == 3'd1) | (MD_Op_E == 3'd4) | (MD_Op_E == 3'd6);
    a_neg    = sgn_a & SrcA_E[WIDTH-1];
    b_neg    = sgn_b & SrcB_E[WIDTH-1];
    a_mag    = a_neg ? -SrcA_E : SrcA_E;
    b_mag    = b_neg ? -SrcB_E : SrcB_E;
    div_zero = in_div & (SrcB_E == '0);
    div_ovf  = in_div & ~MD_Op_E[0] & (SrcA_E == {1'b1, {(WIDTH-1){1'b0}}}) & (SrcB_E == '1);
    fast     = div_zero | div_ovf;
    if (div_zero) fast_res = MD_Op_E[1] ? SrcA_E : '1;
    else          fast_res = MD_Op_E[1] ? '0 : SrcA_E;
    accept   = (state == S_IDLE) & Start_E & ~Flush_E;
    last     = (cnt == CW'(WIDTH-1));
  end

  // One iteration; acc holds {hi, multiplier} for multiply and {remainder, dividend/quotient} for divide
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    div_ge    = div_shift[WIDTH] | ~div_diff[WIDTH];
    if (op[2]) begin
      if (div_ge) acc_nxt = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else        acc_nxt = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod = neg_res ? -acc_nxt : acc_nxt;
    quo  = acc_nxt[WIDTH-1:0];
    rem  = acc_nxt[2*WIDTH-1:WIDTH];
    case (op)
      3'd0:    final_res = prod[WIDTH-1:0];
      3'd4:    final_res = neg_res ? -quo : quo;
      3'd5:    final_res = quo;
      3'd6:    final_res = neg_rem ? -rem : rem;
      3'd7:    final_res = rem;
      default: final_res = prod[2*WIDTH-1:WIDTH];
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    Stall_MD  = 1'b0;
    case (state)
      S_IDLE: begin
        Stall_MD = accept;
        if (accept) state_nxt = fast ? S_DONE : S_CALC;
      end
      S_CALC: begin
        // A flush releases the pipeline immediately rather than at the next edge
        Stall_MD = ~Flush_E;
        if (Flush_E)   state_nxt = S_IDLE;
        else if (last) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt      <= '0;
      op       <= '0;
      opnd     <= '0;
      acc      <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      MD_Out_E <= '0;
      Done_MD  <= 1'b0;
      Busy_MD  <= 1'b0;
    end else begin
      Done_MD <= (state_nxt == S_DONE);
      Busy_MD <= (state_nxt == S_CALC);
      if (accept) begin
        op      <= MD_Op_E;
        opnd    <= in_div ? b_mag : a_mag;
        acc     <= {{WIDTH{1'b0}}, (in_div ? a_mag : b_mag)};
        neg_res <= a_neg ^ b_neg;
        neg_rem <= a_neg;
        cnt     <= '0;
        if (fast) MD_Out_E <= fast_res;
      end else if ((state == S_CALC) && !Flush_E) begin
        acc <= acc_nxt;
        cnt <= cnt + CW'(1);
        if (last) MD_Out_E <= final_res;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed ops push expected results,
// a negedge monitor pops and compares on every Done_MD pulse.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  md_op = '0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        stall, done, busy;
  logic [31:0] md_out;

  typedef struct {
    logic [31:0] val;
    string       name;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] last_exp = '0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .CLK(clk), .RST(rst), .Start_E(start), .Flush_E(flush), .MD_Op_E(md_op),
    .SrcA_E(src_a), .SrcB_E(src_b), .Stall_MD(stall), .Done_MD(done),
    .Busy_MD(busy), .MD_Out_E(md_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // Monitor: every Done_MD pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got result %h with no op outstanding", md_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk(e.name, md_out, e.val);
      end
    end
  end

  // Issue one op at the next cycle; measure cycles to Done_MD and stalled cycles
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_v, input int exp_lat, input string name,
                        input bit hold);
    int cyc;
    int stalls;
    bit got;
    @(posedge clk); #1;
    start = 1'b1; md_op = op; src_a = a; src_b = b;
    sb.push_back('{exp_v, name});
    last_exp = exp_v;
    cyc = 0; stalls = 0; got = 0;
    while (!got && cyc < 100) begin
      #2;
      if (stall) stalls++;
      if (done) got = 1;
      else begin
        @(posedge clk); #1;
        cyc++;
        if (!hold) start = 1'b0;
      end
    end
    if (!hold) start = 1'b0;
    chk({name, "_latency"}, 32'(cyc), 32'(exp_lat));
    chk({name, "_stall_cycles"}, 32'(stalls), 32'(exp_lat));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #3;
    chk("reset_stall", {31'b0, stall}, 32'd0);
    chk("reset_done",  {31'b0, done},  32'd0);
    chk("reset_busy",  {31'b0, busy},  32'd0);
    chk("reset_out",   md_out,         32'd0);
    @(negedge clk); rst = 1'b0;

    run_op(3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, "mul_7_m3",   0);
    run_op(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33, "mulh_min",   0);
    run_op(3'd3, 32'h80000000, 32'h80000000, 32'h40000000, 33, "mulhu_min",  0);
    run_op(3'd2, 32'h80000000, 32'h80000000, 32'hC0000000, 33, "mulhsu_min", 0);
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu_max",  0);
    run_op(3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, "div_m7_2",   0);
    run_op(3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, "rem_m7_2",   0);
    run_op(3'd5, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 33, "divu_m7_2",  0);
    run_op(3'd7, 32'hFFFFFFF9, 32'd2,        32'h00000001, 33, "remu_m7_2",  0);
    run_op(3'd5, 32'h00001234, 32'd0,        32'hFFFFFFFF, 1,  "divu_by0",   0);
    run_op(3'd7, 32'h00001234, 32'd0,        32'h00001234, 1,  "remu_by0",   0);
    run_op(3'd4, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1,  "div_by0",    0);
    run_op(3'd6, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1,  "rem_by0",    0);
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  "div_ovf",    0);
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,  "rem_ovf",    0);

    // Flush during iteration 5: no completion, result register untouched
    @(posedge clk); #1;
    start = 1'b1; md_op = 3'd0; src_a = 32'd3; src_b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    flush = 1'b1;
    #2;
    chk("flush_stall_same_cycle", {31'b0, stall}, 32'd0);
    chk("flush_busy_before",      {31'b0, busy},  32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    #2;
    chk("flush_busy_after",  {31'b0, busy},  32'd0);
    chk("flush_done_after",  {31'b0, done},  32'd0);
    chk("flush_out_kept",    md_out,         last_exp);
    repeat (4) @(posedge clk);

    // Start_E held through CALC and DONE, then a second MUL at T+34
    run_op(3'd0, 32'd5,        32'd6, 32'd30,        33, "mul_hold",  1);
    run_op(3'd0, 32'h12345678, 32'd3, 32'h369D0368, 33, "mul_b2b",   0);

    // Asynchronous reset at iteration 10
    @(posedge clk); #1;
    start = 1'b1; md_op = 3'd0; src_a = 32'd9; src_b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    #2;
    chk("rst_mid_stall", {31'b0, stall}, 32'd0);
    chk("rst_mid_busy",  {31'b0, busy},  32'd0);
    chk("rst_mid_out",   md_out,         32'd0);
    last_exp = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(3'd0, 32'd100, 32'd200, 32'h00004E20, 33, "mul_after_rst", 0);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
